// File: rtl/arbiter_wrr.sv
// rtl/arbiter_wrr.sv - weighted round-robin arbiter with per-port grant quantum
//
// Arbitrates NUM_PORTS requesters for one shared resource. Each port may hold
// the grant for weight+1 consecutive cycles before ownership moves on, in
// round-robin order starting after the current owner. Handover between owners
// inserts no idle cycle. All outputs are registered.
//
// Optional feature macro: ARBITER_WRR_LOCK_EN adds the `lock` input, which
// suppresses quantum expiry while the owner keeps requesting.
//
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset
//   request  in   [NUM_PORTS] per-port request, held while the port wants the resource
//   weight   in   [NUM_PORTS*WEIGHT_WIDTH] per-port quantum, field p at p*WEIGHT_WIDTH
//   lock     in   (ARBITER_WRR_LOCK_EN only) hold the current owner past its quantum
//   grant    out  [NUM_PORTS] registered one-hot grant, or zero
//   select   out  [SEL_WIDTH] registered index of the granted port, 0 when idle
//   active   out  registered, high whenever grant is nonzero

module arbiter_wrr #(
    parameter int NUM_PORTS    = 6,
    parameter int WEIGHT_WIDTH = 4,
    parameter int SEL_WIDTH    = $clog2(NUM_PORTS)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_PORTS-1:0]              request,
    input  logic [NUM_PORTS*WEIGHT_WIDTH-1:0] weight,
`ifdef ARBITER_WRR_LOCK_EN
    input  logic                              lock,
`endif
    output logic [NUM_PORTS-1:0]              grant,
    output logic [SEL_WIDTH-1:0]              select,
    output logic                              active
);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [SEL_WIDTH-1:0]    cur_q, cur_d;
    logic [WEIGHT_WIDTH-1:0] cnt_q, cnt_d;
    logic [SEL_WIDTH-1:0]    ptr_q, ptr_d;

    logic [NUM_PORTS-1:0]    grant_d;
    logic [SEL_WIDTH-1:0]    select_d;
    logic                    active_d;

    // Per-port weight fields unpacked so the winner index selects directly.
    logic [WEIGHT_WIDTH-1:0] wt [NUM_PORTS];

    logic [SEL_WIDTH-1:0]    cur_inc;
    logic [SEL_WIDTH-1:0]    start;
    logic                    reassign;
    logic                    hold_lock;
    logic                    found;
    logic [SEL_WIDTH-1:0]    win;

    // First requesting port scanning start, start+1, ... wrapping at NUM_PORTS.
    function automatic void rr_search(
        input  logic [NUM_PORTS-1:0] req,
        input  logic [SEL_WIDTH-1:0] from,
        output logic                 hit,
        output logic [SEL_WIDTH-1:0] idx_out
    );
        int idx;
        hit     = 1'b0;
        idx_out = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = int'(from) + i;
            if (idx >= NUM_PORTS) begin
                idx = idx - NUM_PORTS;
            end
            if (!hit && req[SEL_WIDTH'(idx)]) begin
                hit     = 1'b1;
                idx_out = SEL_WIDTH'(idx);
            end
        end
    endfunction

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            wt[p] = weight[p*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cur_q   <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
            grant   <= '0;
            select  <= '0;
            active  <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            grant   <= grant_d;
            select  <= select_d;
            active  <= active_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        start    = ptr_q;
        reassign = 1'b0;
        found    = 1'b0;
        win      = '0;
        grant_d  = '0;
        select_d = '0;
        active_d = 1'b0;

`ifdef ARBITER_WRR_LOCK_EN
        hold_lock = lock;
`else
        hold_lock = 1'b0;
`endif

        cur_inc = (cur_q == SEL_WIDTH'(NUM_PORTS - 1)) ? '0 : cur_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (|request) begin
                    start    = ptr_q;
                    reassign = 1'b1;
                end
            end
            OWN: begin
                // Release or expired quantum: search from the port after the
                // owner; the owner itself is the last candidate, so a lone
                // requester is regranted with no gap.
                if (!request[cur_q] || (cnt_q == '0 && !hold_lock)) begin
                    start    = cur_inc;
                    reassign = 1'b1;
                    ptr_d    = cur_inc;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        rr_search(request, start, found, win);

        if (reassign) begin
            if (found) begin
                state_d = OWN;
                cur_d   = win;
                cnt_d   = wt[win];
            end else begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        end

        // Outputs register the owner that takes effect after this edge.
        if (state_d == OWN) begin
            grant_d[cur_d] = 1'b1;
            select_d       = cur_d;
            active_d       = 1'b1;
        end
    end

endmodule

// File: tb/tb_arbiter_wrr.sv
// tb/tb_arbiter_wrr.sv - self-checking bench for arbiter_wrr

module tb_arbiter_wrr;

    localparam int N  = 6;
    localparam int WW = 4;
    localparam int SW = $clog2(N);

    logic          clk     = 1'b0;
    logic          rst     = 1'b1;
    logic [N-1:0]  request = '0;
    logic [N*WW-1:0] weight = '0;
    logic          lock    = 1'b0;
    logic [N-1:0]  grant;
    logic [SW-1:0] select;
    logic          active;

    int checks   = 0;
    int errors   = 0;
    bit model_on = 1'b0;

    always #5 clk = ~clk;

    arbiter_wrr #(
        .NUM_PORTS    (N),
        .WEIGHT_WIDTH (WW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .request (request),
        .weight  (weight),
`ifdef ARBITER_WRR_LOCK_EN
        .lock    (lock),
`endif
        .grant   (grant),
        .select  (select),
        .active  (active)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    // Model: owner (-1 = none), cycles held so far and the quota fixed at grant time.
    int m_owner = -1;
    int m_held  = 0;
    int m_quota = 0;
    int m_ptr   = 0;

    function automatic int first_req(input logic [N-1:0] req, input int s);
        for (int k = 0; k < N; k++) begin
            if (req[(s + k) % N]) return (s + k) % N;
        end
        return -1;
    endfunction

    task automatic m_grab(input int s);
        m_owner = first_req(request, s);
        m_held  = 1;
        if (m_owner >= 0) m_quota = int'(weight[m_owner*WW +: WW]) + 1;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_owner = -1;
            m_ptr   = 0;
            m_held  = 0;
        end else if (m_owner < 0) begin
            if (request != '0) m_grab(m_ptr);
        end else if (!request[m_owner] || (m_held >= m_quota && !lock)) begin
            m_ptr = (m_owner + 1) % N;
            m_grab(m_ptr);
        end else begin
            m_held++;
        end
    end

    always @(negedge clk) begin : cmp
        logic [N-1:0]  eg;
        logic [SW-1:0] es;
        if (model_on) begin
            eg = '0;
            es = '0;
            if (m_owner >= 0) begin
                eg[m_owner] = 1'b1;
                es = SW'(m_owner);
            end
            check("model_grant", grant, eg);
            check("model_select", select, es);
            check("model_active", active, m_owner >= 0);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        request = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [N-1:0]  rot_g [5] = '{6'b000001, 6'b000010, 6'b000100, 6'b001000, 6'b000001};
    logic [SW-1:0] rot_s [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    logic [N-1:0]  wrr_g [10] = '{6'b000010, 6'b000010, 6'b000010, 6'b000010, 6'b000100,
                                  6'b000010, 6'b000010, 6'b000010, 6'b000010, 6'b000100};

    initial begin
        // Reset held with every port requesting.
        @(negedge clk);
        model_on = 1'b1;
        request  = 6'b111111;
        repeat (3) begin
            @(negedge clk);
            check("rst_grant", grant, 0);
            check("rst_select", select, 0);
            check("rst_active", active, 0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("first_grant", grant, 6'b000001);
        check("first_select", select, 0);

        // Zero weights rotate every cycle.
        weight = '0;
        do_reset();
        request = 6'b001111;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("rot_grant", grant, rot_g[k]);
            check("rot_select", select, rot_s[k]);
        end

        // Port 1 weight 3, port 2 weight 0.
        weight = '0;
        weight[1*WW +: WW] = 4'd3;
        do_reset();
        request = 6'b000110;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("wrr_grant", grant, wrr_g[k]);
            check("wrr_active", active, 1);
        end

        // Early release hands over with no gap.
        weight = '0;
        weight[0 +: WW] = 4'd7;
        do_reset();
        request = 6'b001001;
        repeat (2) begin
            @(negedge clk);
            check("early_hold", grant, 6'b000001);
        end
        request = 6'b001000;
        @(negedge clk);
        check("early_handover", grant, 6'b001000);
        check("early_select", select, 3);

        // Lone requester regranted across quantum boundaries, then reset mid-grant.
        weight = '0;
        weight[2*WW +: WW] = 4'd1;
        do_reset();
        request = 6'b000100;
        repeat (6) begin
            @(negedge clk);
            check("single_grant", grant, 6'b000100);
            check("single_select", select, 2);
        end
        rst = 1'b1;
        @(negedge clk);
        check("midrst_grant", grant, 0);
        check("midrst_select", select, 0);
        check("midrst_active", active, 0);
        rst = 1'b0;

`ifdef ARBITER_WRR_LOCK_EN
        // Lock holds port 0 past its single-cycle quantum.
        weight = '0;
        do_reset();
        lock    = 1'b1;
        request = 6'b000011;
        repeat (10) begin
            @(negedge clk);
            check("lock_hold", grant, 6'b000001);
        end
        lock = 1'b0;
        @(negedge clk);
        check("lock_release", grant, 6'b000010);
`endif

        // Mixed patterns with weights changing mid-ownership; model checks each cycle.
        do_reset();
        for (int k = 0; k < 60; k++) begin
            for (int p = 0; p < N; p++) weight[p*WW +: WW] = WW'($urandom_range(0, 3));
            request = N'((k * 37 + 11) % 64);
            if (k % 7 == 3) request = '0;
`ifdef ARBITER_WRR_LOCK_EN
            lock = (k % 5 == 1);
`endif
            if (k == 40) rst = 1'b1;
            if (k == 41) rst = 1'b0;
            @(negedge clk);
        end

        lock = 1'b0;
        @(negedge clk);
        model_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
